// File: rtl/smg_pkg.sv
// smg_pkg: shared constants and dwell arithmetic
// for the 7-segment scan driver.
package smg_pkg;

  localparam int DIGITS_DEF = 6;

  localparam logic [DIGITS_DEF-1:0] SEL_OFF = '1;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int dwell_cycles(
    input int clk_hz,
    input int scan_us
  );
    return clk_hz / 1_000_000 * scan_us;
  endfunction

endpackage

// File: rtl/smg_scan_module_if.sv
// smg_scan_module_if: BCD load port between the
// binary-to-BCD splitter and the scan driver.
interface smg_scan_module_if #(
  parameter int DIGITS = 6
);

  logic [4*DIGITS-1:0] BCD_Data;
  logic                Update;

  modport master (
    output BCD_Data,
    output Update
  );

  modport slave (
    input BCD_Data,
    input Update
  );

endinterface

// File: rtl/smg_tick_gen.sv
// smg_tick_gen: free-running dwell counter
// with end-of-dwell and blank-phase flags.
module smg_tick_gen #(
  parameter int DWELL = 10,
  parameter int BLANK = 2
) (
  input  logic CLK,
  input  logic RSTn,
  output logic o_dwell_end,
  output logic o_blank_phase
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  assign o_dwell_end = (r_cnt == CW'(DWELL - 1));

  assign w_cnt_nxt = o_dwell_end ? '0 : r_cnt + 1'b1;

  // Flag describes the coming cycle so the
  // caller's registered selects line up with it.
  assign o_blank_phase = (w_cnt_nxt < CW'(BLANK));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/smg_scan_module.sv
// smg_scan_module: 6-digit common-anode scan driver
// with tear-free shadow, ghost blanking and LZ blanking.
module smg_scan_module
  import smg_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int DIGITS       = DIGITS_DEF,
  parameter int SCAN_US      = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int LZ_BLANK     = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  smg_scan_module_if.slave  bus,
  output logic [3:0]        Number_Data,
  output logic [DIGITS-1:0] Scan_Sig,
  output logic              Frame_Done
);

  localparam int DWELL =
    dwell_cycles(CLK_FREQ_HZ, SCAN_US);
  localparam int IW =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] W_OFF =
    {DIGITS{SEL_OFF[0]}};

  logic                  w_dwell_end;
  logic                  w_blank;
  logic                  w_frame_end;
  logic [IW-1:0]         w_idx_nxt;
  logic [4*DIGITS-1:0]   w_shadow_nxt;
  logic [3:0]            w_digit_nxt;
  logic [DIGITS-1:0]     w_onehot;
  logic [DIGITS-1:0]     w_sup;
  logic                  w_hi_zero;
  logic [3:0]            w_dig;

  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [4*DIGITS-1:0]   r_stage;
  logic                  r_pend;
  logic [3:0]            r_num;
  logic [DIGITS-1:0]     r_sel;

  smg_tick_gen #(
    .DWELL (DWELL),
    .BLANK (BLANK_CYCLES)
  ) u_tick (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .o_dwell_end   (w_dwell_end),
    .o_blank_phase (w_blank)
  );

  assign w_frame_end = w_dwell_end && (r_idx == LAST);

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_dwell_end) begin
      w_idx_nxt = (r_idx == LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Value the shadow holds next cycle; also feeds
  // Number_Data so a frame-end load shows at once.
  always_comb begin
    w_shadow_nxt = r_shadow;
    unique case (1'b1)
      w_frame_end && bus.Update:
        w_shadow_nxt = bus.BCD_Data;
      w_frame_end && !bus.Update && r_pend:
        w_shadow_nxt = r_stage;
      default: ;
    endcase
  end

  assign w_digit_nxt = w_shadow_nxt[4*w_idx_nxt +: 4];
  assign w_onehot    = DIGITS'(1) << w_idx_nxt;

  // Scan from the top digit down, tracking whether
  // everything more significant is still zero.
  always_comb begin
    w_sup     = '0;
    w_hi_zero = 1'b1;
    w_dig     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_dig     = r_shadow[4*i +: 4];
      w_hi_zero = w_hi_zero && (w_dig == 4'd0);
      w_sup[i]  = (w_dig > BCD_MAX) ||
                  ((LZ_BLANK != 0) && (i > 0) &&
                   w_hi_zero);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_shadow <= '0;
      r_stage  <= '0;
      r_pend   <= 1'b0;
    end else begin
      unique case (1'b1)
        w_frame_end: begin
          r_shadow <= w_shadow_nxt;
          r_pend   <= 1'b0;
        end
        bus.Update && !w_frame_end: begin
          r_stage <= bus.BCD_Data;
          r_pend  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_idx <= '0;
      r_num <= '0;
      r_sel <= W_OFF;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_dwell_end) begin
        r_num <= w_digit_nxt;
      end
      r_sel <= (w_blank || w_sup[w_idx_nxt]) ?
               W_OFF : ~w_onehot;
    end
  end

  assign Number_Data = r_num;
  assign Scan_Sig    = r_sel;
  assign Frame_Done  = w_frame_end;

endmodule

// File: tb/tb_smg_scan_module.sv
// tb_smg_scan_module: directed + random stimulus
// against a frame-level model of the scan driver.
module tb_smg_scan_module;

  localparam int DIG = 6;
  localparam int DW  = 10;
  localparam int BL  = 2;
  localparam int FR  = DW * DIG;

  logic       CLK  = 1'b0;
  logic       RSTn = 1'b0;
  logic [3:0] Number_Data;
  logic [5:0] Scan_Sig;
  logic       Frame_Done;

  smg_scan_module_if #(.DIGITS(DIG)) bus ();

  smg_scan_module #(
    .CLK_FREQ_HZ  (1_000_000),
    .DIGITS       (DIG),
    .SCAN_US      (10),
    .BLANK_CYCLES (BL),
    .LZ_BLANK     (1)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .bus         (bus),
    .Number_Data (Number_Data),
    .Scan_Sig    (Scan_Sig),
    .Frame_Done  (Frame_Done)
  );

  always #5 CLK = ~CLK;

  int          n_run;
  int          n_fail;
  logic [23:0] m_shadow;
  logic [23:0] m_stage;
  bit          m_pend;
  int          m_n;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, m_n, got, exp);
    end
  endtask

  function automatic bit m_sup(
    input logic [23:0] s,
    input int          i
  );
    logic [23:0] hi;
    hi = s >> (4 * i);
    return (hi[3:0] > 4'd9) ||
           ((i > 0) && (hi == 24'd0));
  endfunction

  function automatic logic [23:0] rnd_bcd();
    logic [23:0] r;
    int          nz;
    r  = '0;
    nz = int'($urandom_range(0, 6));
    for (int i = 0; i < nz; i++) begin
      if ($urandom_range(0, 7) == 0)
        r[4*i +: 4] = 4'(10 + $urandom_range(0, 5));
      else if ($urandom_range(0, 3) == 0)
        r[4*i +: 4] = 4'd0;
      else
        r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // One clock: drive, check mid-cycle, then advance model.
  task automatic step(
    input bit          upd,
    input logic [23:0] d
  );
    int          pos;
    int          idx;
    int          c;
    logic [5:0]  sel;
    logic [23:0] dig;
    bus.Update   = upd;
    bus.BCD_Data = d;
    pos = m_n % FR;
    idx = pos / DW;
    c   = pos % DW;
    dig = (m_shadow >> (4 * idx)) & 24'hF;
    sel = (c < BL || m_sup(m_shadow, idx)) ?
          6'h3F : ~(6'd1 << idx);
    @(negedge CLK);
    chk("num", 32'(Number_Data), 32'(dig));
    chk("sel", 32'(Scan_Sig), 32'(sel));
    chk("fdone", 32'(Frame_Done), 32'(pos == FR - 1));
    @(posedge CLK);
    if (pos == FR - 1) begin
      if (upd) m_shadow = d;
      else if (m_pend) m_shadow = m_stage;
      m_pend = 1'b0;
    end else if (upd) begin
      m_stage = d;
      m_pend  = 1'b1;
    end
    m_n++;
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 24'($urandom));
  endtask

  task automatic run_to(input int p);
    while (m_n % FR != p) step(1'b0, 24'($urandom));
  endtask

  task automatic mid_reset();
    bus.Update = 1'b0;
    RSTn = 1'b0;
    #1;
    chk("rst_sel", 32'(Scan_Sig), 32'h3F);
    chk("rst_num", 32'(Number_Data), 32'h0);
    chk("rst_fd", 32'(Frame_Done), 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RSTn     = 1'b1;
    m_shadow = '0;
    m_stage  = '0;
    m_pend   = 1'b0;
    m_n      = 0;
  endtask

  initial begin
    n_run        = 0;
    n_fail       = 0;
    m_shadow     = '0;
    m_stage      = '0;
    m_pend       = 1'b0;
    m_n          = 0;
    bus.Update   = 1'b0;
    bus.BCD_Data = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_sel", 32'(Scan_Sig), 32'h3F);
    chk("reset_num", 32'(Number_Data), 32'h0);
    chk("reset_fd", 32'(Frame_Done), 32'h0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;

    repeat (FR + 5) step(1'b0, 24'h0);

    step(1'b1, 24'h123456);
    run_to(0);
    idle(FR + 2);

    step(1'b1, 24'h000042);
    run_to(0);
    idle(FR + 3);

    run_to(15);
    step(1'b1, 24'h111111);
    run_to(50);
    step(1'b1, 24'h222222);
    run_to(0);
    idle(FR);

    run_to(FR - 1);
    step(1'b1, 24'h000007);
    idle(FR);

    step(1'b1, 24'h1234A6);
    run_to(0);
    idle(FR);
    run_to(35);
    mid_reset();
    idle(FR + 5);

    for (int k = 0; k < 900; k++)
      step($urandom_range(0, 15) == 0, rnd_bcd());

    run_to(FR - 1);
    step(1'b1, rnd_bcd());
    idle(FR + 1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
